alu_result_fifo: RTL



---
 rtl/alu_result_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// Circular result buffer between the ALU and the hex-display stage, with a
// first-word-fall-through read, an occupancy count, flush, and a sticky overflow flag.
// Build option ALU_FIFO_OVERWRITE_EN: a write while full replaces the oldest entry.
// When it is undefined, a write while full is dropped.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic full;
  logic empty;
  logic clear;
  logic push;
  logic pop;
  logic drop;
  logic overwrite;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign clear    = reset | flush;
  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;

`ifdef ALU_FIFO_OVERWRITE_EN
  // When the buffer is full and no pop happens, the new write takes the oldest slot.
  // In that case wr_ptr equals rd_ptr, so both pointers advance together.
  assign wr_ready  = 1'b1;
  assign overwrite = wr_valid & full & ~pop;
  assign drop      = 1'b0;
`else
  assign wr_ready  = ~full;
  assign overwrite = 1'b0;
  assign drop      = wr_valid & full;
`endif

  assign push = wr_valid & wr_ready;

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop | overwrite)
        rd_ptr <= rd_ptr + AW'(1);
      // An overwrite is a push and a pop at once, so the count does not change.
      case ({push & ~overwrite, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop | overwrite)
        overflow_q <= 1'b1;
    end
  end

  // The storage array has no reset. Entries that are not valid are masked at the read port.
  always_ff @(posedge clk) begin
    if (push & ~clear)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data  = empty ? '0 : mem[rd_ptr];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
